// File: rtl/apb_req_bridge.sv
// apb_req_bridge: single-outstanding core data port to APB master bridge.
// Local decode/partial-write rejection and bounded ACCESS-phase timeout.
module apb_req_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic [31:0]               data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [31:0]               data_wdata_i,
  output logic                      data_rvalid_o,
  output logic [31:0]               data_rdata_o,
  output logic                      data_err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [31:0]               pwdata,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  input  logic [31:0]               prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TL = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TLIM = CW'(TL);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          we_q;
  logic          err_q;
  logic          mapped;
  logic          bad_we;
  logic          reject;
  logic          grant;
  logic          timeout;
  logic          unused_addr;

  // Both windows are 32 KiB aligned, so bits [31:15] identify them.
  assign mapped = (data_addr_i[31:15] == 17'h03420) ||
                  (data_addr_i[31:15] == 17'h03422);
  assign bad_we = data_we_i && (data_be_i != 4'hF);
  assign reject = !mapped || bad_we;
  assign grant  = (state == IDLE) && data_req_i;

  // Fires on the last permitted ACCESS cycle with no pready.
  assign timeout = (TIMEOUT_CYCLES != 0) && !pready && (cnt == TLIM);

  assign data_gnt_o   = grant;
  assign data_err_o   = data_rvalid_o & err_q;
  assign data_rdata_o = data_rvalid_o ? rdata_q : 32'h0;
  assign paddr        = {addr_q[APB_ADDR_WIDTH-1:2], 2'b00};
  assign pwdata       = wdata_q;
  assign pwrite       = we_q;
  assign unused_addr  = ^addr_q[1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and APB/response strobes.
  always_comb begin
    state_n       = state;
    psel          = 1'b0;
    penable       = 1'b0;
    data_rvalid_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_req_i) state_n = reject ? RESP : SETUP;
      end
      SETUP: begin
        psel    = 1'b1;
        state_n = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || timeout) state_n = RESP;
      end
      RESP: begin
        data_rvalid_o = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counts ACCESS cycles spent waiting for pready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (state == ACCESS && !pready) cnt <= cnt + CW'(1);
    else                              cnt <= '0;
  end

  // Request capture and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      if (grant) begin
        addr_q  <= data_addr_i;
        wdata_q <= data_wdata_i;
        we_q    <= data_we_i;
        err_q   <= reject;
        rdata_q <= 32'h0;
      end
      if (state == ACCESS && pready) begin
        err_q   <= pslverr;
        rdata_q <= (!we_q && !pslverr) ? prdata : 32'h0;
      end else if (state == ACCESS && timeout) begin
        err_q   <= 1'b1;
        rdata_q <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_apb_req_bridge.sv
// tb_apb_req_bridge: directed and randomized checks of apb_req_bridge
// against a transaction-level latency/response model.
module tb_apb_req_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  apb_req_bridge #(
    .APB_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_req_i(req),
    .data_gnt_o(gnt),
    .data_addr_i(addr),
    .data_we_i(we),
    .data_be_i(be),
    .data_wdata_i(wdata),
    .data_rvalid_o(rvalid),
    .data_rdata_o(rdata),
    .data_err_o(err),
    .paddr(paddr),
    .pwdata(pwdata),
    .pwrite(pwrite),
    .psel(psel),
    .penable(penable),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_map(input logic [31:0] a);
    return (a >= 32'h1A10_0000 && a <= 32'h1A10_7FFF) ||
           (a >= 32'h1A11_0000 && a <= 32'h1A11_7FFF);
  endfunction

  // waits >= TO means the slave never answers within the timeout.
  task automatic txn(input logic [31:0] a, input logic w,
                     input logic [3:0] b, input logic [31:0] wd,
                     input int waits, input logic serr,
                     input logic [31:0] prd, input logic hold);
    logic        rej;
    logic        tmo;
    logic        e_err;
    logic [31:0] e_rd;
    int          fin;
    rej   = !in_map(a) || (w && b != 4'hF);
    tmo   = !rej && waits >= TO;
    fin   = rej ? 1 : (tmo ? TO + 2 : 3 + waits);
    e_err = rej || tmo || serr;
    e_rd  = (!e_err && !w) ? prd : 32'h0;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; be = b; wdata = wd;
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    #1;
    chk("gnt_c0", {31'b0, gnt}, 32'd1);
    for (int c = 1; c <= fin; c++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      pready  = !rej && !tmo && (c == 2 + waits);
      pslverr = pready && serr;
      prdata  = pready ? prd : $urandom;
      #1;
      chk("gnt_busy", {31'b0, gnt}, 32'd0);
      chk("psel", {31'b0, psel}, {31'b0, !rej && c < fin});
      chk("penable", {31'b0, penable},
          {31'b0, !rej && c >= 2 && c < fin});
      chk("rvalid", {31'b0, rvalid}, {31'b0, c == fin});
      if (!rej && c < fin) begin
        chk("paddr", paddr, a & 32'hFFFF_FFFC);
        chk("pwrite", {31'b0, pwrite}, {31'b0, w});
        chk("pwdata", pwdata, wd);
      end
      if (c == fin) begin
        chk("err", {31'b0, err}, {31'b0, e_err});
        chk("rdata", rdata, e_rd);
        req = 1'b0;
      end
    end
    pready = 1'b0; pslverr = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    logic        rw;
    logic [3:0]  rb;
    int          sel;
    rst = 1'b1; req = 1'b0; addr = 0; we = 0; be = 0; wdata = 0;
    prdata = 0; pready = 0; pslverr = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_psel", {31'b0, psel}, 32'd0);
    chk("rst_penable", {31'b0, penable}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b1; #1;
    chk("gnt_follow1", {31'b0, gnt}, 32'd1);
    req = 1'b0; #1;
    chk("gnt_follow0", {31'b0, gnt}, 32'd0);

    txn(32'h1A10_3004, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    txn(32'h1A10_1003, 1'b1, 4'hF, 32'h1234_5678, 3, 1'b0,
        32'hCAFE_F00D, 1'b0);
    txn(32'h1A10_8000, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h1111_1111, 1'b0);
    txn(32'h1A10_0000, 1'b1, 4'h3, 32'hAAAA_5555, 0, 1'b0,
        32'h2222_2222, 1'b0);
    txn(32'h1A11_00AA, 1'b0, 4'hF, 32'h0, 0, 1'b1, 32'h3333_3333, 1'b0);
    txn(32'h1A10_7FFC, 1'b0, 4'h1, 32'h0, TO, 1'b0, 32'h4444_4444, 1'b0);
    txn(32'h1A10_7FFC, 1'b0, 4'h1, 32'h0, TO - 1, 1'b0,
        32'h5555_5555, 1'b0);
    txn(32'h1A11_7FFF, 1'b1, 4'hF, 32'h7777_0000, 1, 1'b0,
        32'h0, 1'b1);
    txn(32'h1A11_8000, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h0, 1'b1);
    txn(32'h1A0F_FFFF, 1'b1, 4'hF, 32'h0, 0, 1'b0, 32'h0, 1'b0);

    // Reset asserted while the bridge sits in ACCESS.
    @(negedge clk);
    req = 1'b1; addr = 32'h1A10_0010; we = 1'b0; be = 4'hF;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_penable", {31'b0, penable}, 32'd1);
    rst = 1'b1; #1;
    chk("arst_psel", {31'b0, psel}, 32'd0);
    chk("arst_penable", {31'b0, penable}, 32'd0);
    chk("arst_rvalid", {31'b0, rvalid}, 32'd0);
    @(negedge clk);
    #1;
    chk("arst_rvalid2", {31'b0, rvalid}, 32'd0);
    rst = 1'b0;
    txn(32'h1A10_2008, 1'b0, 4'hF, 32'h0, 0, 1'b0, 32'h0BAD_CAFE, 1'b0);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      ra = 32'h1A10_0000 | ($urandom & 32'h7FFF);
      else if (sel == 1) ra = 32'h1A11_0000 | ($urandom & 32'h7FFF);
      else if (sel == 2) ra = $urandom;
      else               ra = 32'h1A10_8000 | ($urandom & 32'h7FFF);
      rw = 1'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      txn(ra, rw, rb, $urandom, $urandom_range(0, TO + 1),
          ($urandom_range(0, 3) == 0), $urandom, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
